// File: rtl/line_write_merge_buffer.sv
// Single-line write-combining buffer: merges masked CPU word writes into one
// held line and drains it to memory with a per-byte enable mask.
module line_write_merge_buffer #(
  parameter int ADDR_WIDTH = 16,
  parameter int WORD_BYTES = 2,
  parameter int LINE_WORDS = 8,
  parameter int AUTO_DRAIN = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                cpu_write,
  input  logic [ADDR_WIDTH-1:0]               cpu_addr,
  input  logic [8*WORD_BYTES-1:0]             cpu_wdata,
  input  logic [WORD_BYTES-1:0]               cpu_wmask,
  output logic                                cpu_resp,
  input  logic                                flush,
  output logic                                mem_write,
  output logic [ADDR_WIDTH-1:0]               mem_addr,
  output logic [8*WORD_BYTES*LINE_WORDS-1:0]  mem_wdata,
  output logic [WORD_BYTES*LINE_WORDS-1:0]    mem_byte_en,
  input  logic                                mem_resp,
  output logic                                busy,
  output logic                                line_valid
);

  localparam int LINE_BYTES = WORD_BYTES * LINE_WORDS;
  localparam int OFF_W      = $clog2(LINE_BYTES);
  localparam int TAG_W      = ADDR_WIDTH - OFF_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic [TAG_W-1:0]        tag_q, tag_d;
  logic [8*LINE_BYTES-1:0] data_q, data_d;
  logic [LINE_BYTES-1:0]   dirty_q, dirty_d;
  logic                    resp_q, resp_d;
  logic                    mem_write_q;
  logic                    busy_q;
  logic                    line_valid_q;

  logic [TAG_W-1:0]        cpu_tag_s;
  logic [OFF_W-1:0]        word_base_s;
  logic [OFF_W-1:0]        byte_idx_s;
  logic                    wr_s;
  logic                    hit_s;
  logic                    full_s;
  logic                    merge_s;

  assign cpu_tag_s   = cpu_addr[ADDR_WIDTH-1:OFF_W];
  assign word_base_s = cpu_addr[OFF_W-1:0] & ~OFF_W'(WORD_BYTES - 1);
  // A request still held in the ack cycle is the one just accepted; ignore it.
  assign wr_s        = cpu_write & ~resp_q;
  assign hit_s       = (cpu_tag_s == tag_q);
  assign full_s      = &dirty_q;

  // Next-state, acceptance and ack decision.
  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    resp_d  = 1'b0;
    merge_s = 1'b0;
    case (state_q)
      EMPTY: begin
        if (wr_s) begin
          tag_d   = cpu_tag_s;
          merge_s = 1'b1;
          resp_d  = 1'b1;
          if (|cpu_wmask) begin
            state_d = FILL;
          end else begin
            state_d = EMPTY;
          end
        end else begin
          state_d = EMPTY;
        end
      end
      FILL: begin
        if ((AUTO_DRAIN != 0) && full_s) begin
          state_d = DRAIN;
        end else if (wr_s && hit_s) begin
          merge_s = 1'b1;
          resp_d  = 1'b1;
        end else if (wr_s || flush) begin
          state_d = DRAIN;
        end else begin
          state_d = FILL;
        end
      end
      DRAIN: begin
        if (mem_resp) begin
          state_d = EMPTY;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
  end

  // Byte merge into the held line and dirty-mask maintenance.
  always_comb begin
    data_d     = data_q;
    dirty_d    = dirty_q;
    byte_idx_s = word_base_s;
    if (merge_s) begin
      for (int b = 0; b < WORD_BYTES; b++) begin
        byte_idx_s = word_base_s + OFF_W'(b);
        data_d[{byte_idx_s, 3'b000} +: 8] = cpu_wmask[b] ? cpu_wdata[8*b +: 8]
                                                         : data_q[{byte_idx_s, 3'b000} +: 8];
        dirty_d[byte_idx_s] = dirty_q[byte_idx_s] | cpu_wmask[b];
      end
    end else if ((state_q == DRAIN) && mem_resp) begin
      dirty_d = {LINE_BYTES{1'b0}};
    end else begin
      dirty_d = dirty_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= EMPTY;
      tag_q        <= {TAG_W{1'b0}};
      data_q       <= {(8*LINE_BYTES){1'b0}};
      dirty_q      <= {LINE_BYTES{1'b0}};
      resp_q       <= 1'b0;
      mem_write_q  <= 1'b0;
      busy_q       <= 1'b0;
      line_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      tag_q        <= tag_d;
      data_q       <= data_d;
      dirty_q      <= dirty_d;
      resp_q       <= resp_d;
      mem_write_q  <= (state_d == DRAIN);
      busy_q       <= (state_d == DRAIN);
      line_valid_q <= |dirty_d;
    end
  end

  assign cpu_resp    = resp_q;
  assign mem_write   = mem_write_q;
  assign mem_addr    = {tag_q, {OFF_W{1'b0}}};
  assign mem_wdata   = data_q;
  assign mem_byte_en = dirty_q;
  assign busy        = busy_q;
  assign line_valid  = line_valid_q;

endmodule

// File: tb/tb_line_write_merge_buffer.sv
// Bench for line_write_merge_buffer: directed vector table, corner-case
// sequences, then random traffic against a byte-array line model.
module tb_line_write_merge_buffer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cpu_write = 1'b0;
  logic [15:0]  cpu_addr = 16'h0000;
  logic [15:0]  cpu_wdata = 16'h0000;
  logic [1:0]   cpu_wmask = 2'b00;
  logic         cpu_resp;
  logic         flush = 1'b0;
  logic         mem_write;
  logic [15:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [15:0]  mem_byte_en;
  logic         mem_resp = 1'b0;
  logic         busy;
  logic         line_valid;

  always #5 clk = ~clk;

  line_write_merge_buffer #(
    .ADDR_WIDTH(16), .WORD_BYTES(2), .LINE_WORDS(8), .AUTO_DRAIN(1)
  ) dut (
    .clk(clk), .rst(rst), .cpu_write(cpu_write), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_wmask(cpu_wmask), .cpu_resp(cpu_resp),
    .flush(flush), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_byte_en(mem_byte_en), .mem_resp(mem_resp),
    .busy(busy), .line_valid(line_valid)
  );

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0]  addr;
    logic [15:0]  be;
    logic [127:0] data;
  } drain_t;

  typedef struct {
    bit           is_flush;
    logic [15:0]  addr;
    logic [15:0]  data;
    logic [1:0]   mask;
    bit           exp_valid;
    bit           exp_drain;
    logic [15:0]  exp_addr;
    logic [15:0]  exp_be;
    logic [127:0] exp_data;
  } vec_t;

  drain_t exp_q[$];
  drain_t cur_exp;
  bit     cur_valid = 1'b0;
  bit     drain_seen = 1'b0;
  int     lat_cnt = 0;
  int     mem_lat = 1;

  // Line model: byte data, dirty flags and tag of the held line.
  logic [7:0]  m_data [16];
  bit          m_dirty [16];
  logic [11:0] m_tag = 12'h000;

  function automatic logic [127:0] be_mask(input logic [15:0] be);
    logic [127:0] m;
    m = 128'h0;
    for (int i = 0; i < 16; i++) m[i*8 +: 8] = {8{be[i]}};
    return m;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [15:0] a, input logic [15:0] be, input logic [127:0] d);
    drain_t e;
    e.addr = a; e.be = be; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic check_drain(input string name);
    logic [127:0] m;
    m = be_mask(cur_exp.be);
    chk({name, "_addr"}, mem_addr, cur_exp.addr);
    chk({name, "_be"}, mem_byte_en, cur_exp.be);
    chk({name, "_data"}, mem_wdata & m, cur_exp.data & m);
  endtask

  // One clock: advance to the falling edge and run the memory-side responder.
  task automatic cycle();
    @(negedge clk);
    if (mem_resp) mem_resp = 1'b0;
    if (!mem_write) drain_seen = 1'b0;
    if (mem_write && !drain_seen) begin
      drain_seen = 1'b1;
      lat_cnt = 0;
      if (exp_q.size() == 0) begin
        cur_valid = 1'b0;
        checks++;
        failures++;
        $display("FAIL unexpected_drain actual addr=%0h be=%0h expected no drain", mem_addr, mem_byte_en);
      end else begin
        cur_exp = exp_q.pop_front();
        cur_valid = 1'b1;
        check_drain("drain");
      end
    end
    if (drain_seen && mem_write) begin
      if (lat_cnt >= mem_lat) begin
        mem_resp = 1'b1;
        if (cur_valid) check_drain("drain_hold");
      end else begin
        lat_cnt++;
      end
    end
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [15:0] d, input logic [1:0] m, output int lat);
    cpu_addr = a; cpu_wdata = d; cpu_wmask = m; cpu_write = 1'b1;
    lat = 0;
    do begin
      cycle();
      lat++;
    end while (!cpu_resp && lat < 300);
    cpu_write = 1'b0;
    if (!cpu_resp) begin
      checks++;
      failures++;
      $display("FAIL cpu_resp_timeout actual=no ack expected=ack addr=%0h", a);
    end else begin
      cycle();
      chk("resp_single_cycle", cpu_resp, 1'b0);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || mem_write || busy) && n < 300) begin
      cycle();
      n++;
    end
    chk("pending_drains", exp_q.size(), 0);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    wait_idle();
  endtask

  function automatic bit m_held();
    bit h;
    h = 1'b0;
    for (int i = 0; i < 16; i++) h = h | m_dirty[i];
    return h;
  endfunction

  task automatic m_drain();
    drain_t e;
    e.addr = {m_tag, 4'h0};
    e.be = 16'h0000;
    e.data = 128'h0;
    for (int i = 0; i < 16; i++) begin
      if (m_dirty[i]) begin
        e.be[i] = 1'b1;
        e.data[i*8 +: 8] = m_data[i];
      end
      m_dirty[i] = 1'b0;
    end
    exp_q.push_back(e);
  endtask

  task automatic m_write(input logic [15:0] a, input logic [15:0] d, input logic [1:0] m, output int exp_lat);
    int w;
    bit full;
    exp_lat = 1;
    if (m_held() && a[15:4] != m_tag) begin
      m_drain();
      exp_lat = mem_lat + 3;
    end
    if (!m_held()) m_tag = a[15:4];
    w = int'(a[3:1]);
    for (int b = 0; b < 2; b++) begin
      if (m[b]) begin
        m_data[w*2 + b] = d[b*8 +: 8];
        m_dirty[w*2 + b] = 1'b1;
      end
    end
    full = 1'b1;
    for (int i = 0; i < 16; i++) full = full & m_dirty[i];
    if (full) m_drain();
  endtask

  initial begin
    vec_t         vecs [10];
    int           lat;
    int           exp_lat;
    logic [127:0] d128;
    logic [15:0]  ra;
    logic [15:0]  rd;
    logic [1:0]   rm;

    for (int i = 0; i < 16; i++) begin
      m_data[i] = 8'h00;
      m_dirty[i] = 1'b0;
    end

    vecs[0] = '{1'b0, 16'h0012, 16'hBEEF, 2'b11, 1'b1, 1'b0, 16'h0000, 16'h0000, 128'h0};
    vecs[1] = '{1'b1, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b1, 16'h0010, 16'h000C, 128'hBEEF_0000};
    vecs[2] = '{1'b0, 16'h0014, 16'h00AA, 2'b01, 1'b1, 1'b0, 16'h0000, 16'h0000, 128'h0};
    vecs[3] = '{1'b0, 16'h0014, 16'hBB00, 2'b10, 1'b1, 1'b0, 16'h0000, 16'h0000, 128'h0};
    vecs[4] = '{1'b1, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b1, 16'h0010, 16'h0030, 128'hBBAA_0000_0000};
    vecs[5] = '{1'b1, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0, 16'h0000, 16'h0000, 128'h0};
    vecs[6] = '{1'b0, 16'h0000, 16'h1234, 2'b00, 1'b0, 1'b0, 16'h0000, 16'h0000, 128'h0};
    vecs[7] = '{1'b1, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0, 16'h0000, 16'h0000, 128'h0};
    vecs[8] = '{1'b0, 16'h0106, 16'h5A5A, 2'b11, 1'b1, 1'b0, 16'h0000, 16'h0000, 128'h0};
    vecs[9] = '{1'b1, 16'h0000, 16'h0000, 2'b00, 1'b0, 1'b1, 16'h0100, 16'h00C0, 128'h5A5A_0000_0000_0000};

    // Reset values while reset is held.
    #12;
    chk("reset_cpu_resp", cpu_resp, 1'b0);
    chk("reset_mem_write", mem_write, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_line_valid", line_valid, 1'b0);
    chk("reset_byte_en", mem_byte_en, 16'h0000);
    chk("reset_mem_addr", mem_addr, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    cycle();

    for (int i = 0; i < 10; i++) begin
      if (vecs[i].exp_drain) push_exp(vecs[i].exp_addr, vecs[i].exp_be, vecs[i].exp_data);
      if (vecs[i].is_flush) begin
        do_flush();
      end else begin
        cpu_wr(vecs[i].addr, vecs[i].data, vecs[i].mask, lat);
        chk($sformatf("vec%0d_ack_latency", i), lat, 1);
      end
      wait_idle();
      chk($sformatf("vec%0d_line_valid", i), line_valid, vecs[i].exp_valid);
    end

    // Miss eviction with a 3-cycle memory response.
    mem_lat = 3;
    cpu_wr(16'h0000, 16'h1111, 2'b11, lat);
    push_exp(16'h0000, 16'h0003, 128'h1111);
    cpu_wr(16'h0020, 16'h2222, 2'b11, lat);
    chk("miss_ack_latency", lat, 6);
    chk("miss_line_valid", line_valid, 1'b1);
    push_exp(16'h0020, 16'h0003, 128'h2222);
    do_flush();

    // Auto drain once all sixteen bytes are dirty.
    mem_lat = 1;
    d128 = 128'h0;
    for (int i = 0; i < 8; i++) d128[i*16 +: 16] = 16'hC000 + 16'(i) * 16'h0111;
    push_exp(16'h0040, 16'hFFFF, d128);
    for (int i = 0; i < 8; i++) begin
      cpu_wr(16'h0040 + 16'(2*i), d128[i*16 +: 16], 2'b11, lat);
      chk($sformatf("auto_w%0d_latency", i), lat, 1);
    end
    wait_idle();
    chk("auto_line_valid", line_valid, 1'b0);

    // Flush and hit write together: write first, then a drain holding it.
    cpu_wr(16'h0060, 16'h1111, 2'b11, lat);
    push_exp(16'h0060, 16'h000F, 128'h2222_1111);
    flush = 1'b1;
    cpu_wr(16'h0062, 16'h2222, 2'b11, lat);
    flush = 1'b0;
    chk("flush_hit_latency", lat, 1);
    wait_idle();
    chk("flush_hit_line_valid", line_valid, 1'b0);

    // Reset in the middle of a drain, then a stray memory response.
    cpu_wr(16'h0080, 16'h7777, 2'b11, lat);
    push_exp(16'h0080, 16'h0003, 128'h7777);
    mem_lat = 50;
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    chk("pre_rst_mem_write", mem_write, 1'b1);
    chk("pre_rst_busy", busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_line_valid", line_valid, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    drain_seen = 1'b0;
    mem_resp = 1'b1;
    cycle();
    cycle();
    chk("stray_resp_mem_write", mem_write, 1'b0);
    chk("stray_resp_busy", busy, 1'b0);
    chk("stray_resp_line_valid", line_valid, 1'b0);
    mem_lat = 1;
    cpu_wr(16'h0090, 16'h0033, 2'b01, lat);
    chk("post_rst_latency", lat, 1);
    push_exp(16'h0090, 16'h0001, 128'h33);
    do_flush();

    // Random traffic against the line model.
    for (int n = 0; n < 300; n++) begin
      mem_lat = $urandom_range(0, 4);
      if ($urandom_range(0, 3) == 0) begin
        if (m_held()) m_drain();
        do_flush();
      end else begin
        ra = {10'h000, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15))};
        rd = 16'($urandom);
        rm = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b11;
        m_write(ra, rd, rm, exp_lat);
        cpu_wr(ra, rd, rm, lat);
        chk($sformatf("rand%0d_latency", n), lat, exp_lat);
        wait_idle();
      end
      chk($sformatf("rand%0d_line_valid", n), line_valid, m_held());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
